osc_bank_tdm: RTL and testbench

//  Parametrised multi-channel NCO waveform bank for the SPI DAC path.
//  A single time-multiplexed accumulator and shaper serve NUM_CH oscillators.

---
 rtl/osc_bank_pkg.sv | 19 +
 rtl/osc_shaper.sv | 34 +++
 rtl/osc_bank_tdm.sv | 175 +++++++++++++++++
 tb/tb_osc_bank_tdm.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_bank_pkg.sv
// Shared encodings for the time-multiplexed oscillator bank.
package osc_bank_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_RAMPDN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/osc_shaper.sv
// Combinational waveform shaper: phase MSBs + mode + duty -> offset-binary sample.
// Only the top OSZ+1 phase bits matter, so only those are brought in.
module osc_shaper
  import osc_bank_pkg::*;
#(
  parameter int OSZ = 12
) (
  input  logic [OSZ:0]        phase_msb,
  input  logic [1:0]          mode,
  input  logic [DUTY_W-1:0]   duty,
  output logic [OSZ-1:0]      sample
);

  // Map a phase to a sample; pulse compares the top DUTY_W phase bits to duty.
  function automatic logic [OSZ-1:0] shape(input logic [OSZ:0] p,
                                           input logic [1:0] m,
                                           input logic [DUTY_W-1:0] d);
    logic [OSZ-1:0] h;
    h = p[OSZ-1:0];
    case (mode_e'(m))
      MODE_SAW:    shape = p[OSZ -: OSZ];
      MODE_RAMPDN: shape = ~p[OSZ -: OSZ];
      MODE_TRI:    shape = p[OSZ] ? ~h : h;
      MODE_PULSE:  shape = (p[OSZ -: DUTY_W] < d) ? '1 : '0;
      default:     shape = '0;
    endcase
  endfunction

  // Pure combinational lookup.
  always_comb begin
    sample = shape(phase_msb, mode, duty);
  end

endmodule

// File: rtl/osc_bank_tdm.sv
// Multi-channel NCO bank: one shared accumulator/shaper walks all channels per
// frame, staging samples so dac_out and wrap update together in one clock.
module osc_bank_tdm
  import osc_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PSZ    = 24,
  parameter int OSZ    = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ena,
  input  logic [NUM_CH*PSZ-1:0]    frq,
  input  logic [NUM_CH*2-1:0]      mode,
  input  logic [NUM_CH*DUTY_W-1:0] duty,
  input  logic [NUM_CH-1:0]        sync_en,
  input  logic                     ovr_clr,
  output logic [NUM_CH*OSZ-1:0]    dac_out,
  output logic                     done,
  output logic                     busy,
  output logic [NUM_CH-1:0]        wrap,
  output logic                     overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state, state_nxt;
  logic                start, acc_en, last_ch;
  logic [CH_W-1:0]     ch, ch_prev;

  logic [PSZ-1:0]      frq_arr  [NUM_CH];
  logic [1:0]          mode_arr [NUM_CH];
  logic [DUTY_W-1:0]   duty_arr [NUM_CH];

  logic [PSZ-1:0]      phase_mem [NUM_CH];
  logic [NUM_CH-1:0]   wrap_acc;
  logic [PSZ-1:0]      sum, phase_new;
  logic                carry, sync_hit, wrap_new;

  logic [OSZ:0]        phase_p0;
  logic [1:0]          mode_p0;
  logic [DUTY_W-1:0]   duty_p0;
  logic [CH_W-1:0]     ch_p0;
  logic                vld_p0, last_p0;
  logic [OSZ-1:0]      sample_p0;

  logic [OSZ-1:0]      stage_p1 [NUM_CH];
  logic                last_p1;
  logic [NUM_CH*OSZ-1:0] dac_next;

  // Unpack the flat per-channel input buses.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      frq_arr[i]  = frq[i*PSZ +: PSZ];
      mode_arr[i] = mode[i*2 +: 2];
      duty_arr[i] = duty[i*DUTY_W +: DUTY_W];
    end
  end

  assign last_ch = (ch == CH_W'(NUM_CH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; a frame may only start once the previous one has committed.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    acc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ena && !busy) begin
          start     = 1'b1;
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_en = 1'b1;
        if (last_ch) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Channel index, busy/overrun flags and the valid/last pipeline tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch      <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (start)       ch <= '0;
      else if (acc_en) ch <= last_ch ? '0 : ch + CH_W'(1);
      if (start)        busy <= 1'b1;
      else if (last_p1) busy <= 1'b0;
      if (ena && busy)  overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      vld_p0  <= acc_en;
      last_p0 <= acc_en && last_ch;
      last_p1 <= last_p0;
      done    <= last_p1;
    end
  end

  // Shared accumulator; hard sync uses the previous channel's carry from this frame.
  always_comb begin
    ch_prev        = (ch == '0) ? '0 : ch - CH_W'(1);
    {carry, sum}   = {1'b0, phase_mem[ch]} + {1'b0, frq_arr[ch]};
    sync_hit       = (ch != '0) && sync_en[ch] && wrap_acc[ch_prev];
    phase_new      = sync_hit ? '0 : sum;
    wrap_new       = sync_hit ? 1'b0 : carry;
  end

  // ---- stage p0: accumulate, write back phase and per-channel carry ----
  // Phase store and in-frame carries, written at the active channel index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) phase_mem[i] <= '0;
      wrap_acc <= '0;
    end else if (acc_en) begin
      phase_mem[ch] <= phase_new;
      wrap_acc[ch]  <= wrap_new;
    end
  end

  // Capture the updated phase and shaping controls for the shaper.
  always_ff @(posedge clk) begin
    if (acc_en) begin
      phase_p0 <= phase_new[PSZ-1 -: OSZ+1];
      mode_p0  <= mode_arr[ch];
      duty_p0  <= duty_arr[ch];
      ch_p0    <= ch;
    end
  end

  osc_shaper #(.OSZ(OSZ)) u_shaper (
    .phase_msb (phase_p0),
    .mode      (mode_p0),
    .duty      (duty_p0),
    .sample    (sample_p0)
  );

  // ---- stage p1: shaped samples staged per channel ----
  // Stage each channel's sample until the whole frame is ready.
  always_ff @(posedge clk) begin
    if (vld_p0) stage_p1[ch_p0] <= sample_p0;
  end

  // Flatten the staging array for the atomic output load.
  always_comb begin
    dac_next = '0;
    for (int i = 0; i < NUM_CH; i++) dac_next[i*OSZ +: OSZ] = stage_p1[i];
  end

  // ---- commit: all channel samples and carries update together ----
  // Atomic output load once the last channel has been staged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_out <= '0;
      wrap    <= '0;
    end else if (last_p1) begin
      dac_out <= dac_next;
      wrap    <= wrap_acc;
    end
  end

endmodule

// File: tb/tb_osc_bank_tdm.sv
// Directed bench for osc_bank_tdm with a frame-level scoreboard.
module tb_osc_bank_tdm;

  logic         clk;
  logic         reset_n;
  logic         ena;
  logic [95:0]  frq;
  logic [7:0]   mode;
  logic [31:0]  duty;
  logic [3:0]   sync_en;
  logic         ovr_clr;
  logic [47:0]  dac_out;
  logic         done;
  logic         busy;
  logic [3:0]   wrap;
  logic         overrun;

  typedef struct packed {
    logic [47:0] dac;
    logic [3:0]  wrp;
  } exp_t;

  exp_t         sb_q[$];
  logic [23:0]  m_phase [4];
  logic [47:0]  last_dac;
  logic [3:0]   last_wrap;
  int           n_run;
  int           n_fail;

  osc_bank_tdm #(.NUM_CH(4), .PSZ(24), .OSZ(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (ena),
    .frq     (frq),
    .mode    (mode),
    .duty    (duty),
    .sync_en (sync_en),
    .ovr_clr (ovr_clr),
    .dac_out (dac_out),
    .done    (done),
    .busy    (busy),
    .wrap    (wrap),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_shape(input logic [23:0] p, input logic [1:0] m,
                                            input logic [7:0] d);
    logic [11:0] h;
    h = p[22:11];
    case (m)
      2'd0:    return p[23:12];
      2'd1:    return (p[23:16] < d) ? 12'hFFF : 12'h000;
      2'd2:    return p[23] ? (12'hFFF - h) : h;
      default: return 12'hFFF - p[23:12];
    endcase
  endfunction

  task automatic model_frame(output logic [47:0] d, output logic [3:0] w);
    d = '0;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      logic [24:0] s;
      s = {1'b0, m_phase[i]} + {1'b0, frq[i*24 +: 24]};
      if (i > 0 && sync_en[i] && w[i-1]) s = '0;
      m_phase[i]     = s[23:0];
      w[i]           = s[24];
      d[i*12 +: 12]  = ref_shape(s[23:0], mode[i*2 +: 2], duty[i*8 +: 8]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    sb_q.delete();
  endtask

  // Push the expected frame result and pulse ena; returns at the negedge after E0.
  task automatic start_frame();
    exp_t e;
    model_frame(e.dac, e.wrp);
    sb_q.push_back(e);
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  // start_cnt: how many negedges after E0 have already passed (1 = right after start_frame).
  task automatic wait_done(input string tag, input int start_cnt);
    int   cnt;
    exp_t e;
    cnt = start_cnt;
    while (!done && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, cnt - 1, 6);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_dac"}, dac_out, e.dac);
      chk({tag, "_wrap"}, wrap, e.wrp);
    end
    last_dac  = dac_out;
    last_wrap = wrap;
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic run_frame(input string tag);
    start_frame();
    wait_done(tag, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] tri_exp  [4];
    logic [11:0] pul_exp  [4];
    logic [11:0] sync_exp [5];
    logic [11:0] e12;
    int          nd;

    tri_exp  = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
    pul_exp  = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};
    sync_exp = '{12'h100, 12'h200, 12'h300, 12'h000, 12'h100};
    n_run = 0;
    n_fail = 0;
    clk = 1'b0;
    reset_n = 1'b0;
    ena = 1'b0;
    frq = '0;
    mode = '0;
    duty = '0;
    sync_en = '0;
    ovr_clr = 1'b0;
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset state and frame latency
    chk("rst_dac", dac_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_wrap", wrap, 0);
    start_frame();
    chk("t1_busy_hi", busy, 1);
    wait_done("t1", 1);
    chk("t1_busy_lo", busy, 0);

    // 2: ch0 saw over a full phase cycle, ch3 ramp-down alongside
    do_reset();
    frq[0 +: 24]  = 24'h100000;
    frq[72 +: 24] = 24'h080000;
    mode[6 +: 2]  = 2'd3;
    for (int k = 1; k <= 16; k++) begin
      run_frame("t2");
      e12 = 12'(k * 256);
      chk("t2_ch0", last_dac[11:0], e12);
      chk("t2_wrap0", last_wrap[0], (k == 16));
    end

    // 3: ch1 triangle
    do_reset();
    frq = '0;
    mode = '0;
    frq[24 +: 24] = 24'h400000;
    mode[2 +: 2]  = 2'd2;
    for (int k = 0; k < 4; k++) begin
      run_frame("t3");
      chk("t3_ch1", last_dac[23:12], tri_exp[k]);
    end

    // 4: ch2 pulse at 50% duty, then duty 0
    do_reset();
    frq = '0;
    mode = '0;
    frq[48 +: 24] = 24'h400000;
    mode[4 +: 2]  = 2'd1;
    duty[16 +: 8] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      run_frame("t4");
      chk("t4_ch2", last_dac[35:24], pul_exp[k]);
    end
    duty[16 +: 8] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      run_frame("t4z");
      chk("t4z_ch2", last_dac[35:24], 12'h000);
    end

    // 5: hard sync of ch1 to ch0
    do_reset();
    frq = '0;
    mode = '0;
    duty = '0;
    frq[0 +: 24]  = 24'h400000;
    frq[24 +: 24] = 24'h100000;
    sync_en = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      run_frame("t5");
      chk("t5_ch1", last_dac[23:12], sync_exp[k]);
      if (k == 3) begin
        chk("t5_wrap0", last_wrap[0], 1);
        chk("t5_wrap1", last_wrap[1], 0);
      end
    end

    // 6: ena while busy, overrun set/clear, mid-frame reset
    do_reset();
    sync_en = '0;
    frq = '0;
    frq[0 +: 24] = 24'h300000;
    start_frame();
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    chk("t6_ovr_set", overrun, 1);
    wait_done("t6", 3);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t6_single_done", nd, 0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("t6_ovr_clr", overrun, 0);

    start_frame();
    ena = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    ovr_clr = 1'b0;
    chk("t6_set_wins", overrun, 1);
    wait_done("t6b", 2);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    start_frame();
    @(negedge clk);
    chk("t6_pre_nonzero", (dac_out != 48'd0), 1);
    chk("t6_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_dac", dac_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wrap", wrap, 0);
    chk("t6_rst_done", done, 0);
    sb_q.delete();
    for (int i = 0; i < 4; i++) m_phase[i] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t6_no_done", nd, 0);
    chk("t6_dac_held0", dac_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
